// File: rtl/circuit_bist_pkg.sv
// Shared constants, state encoding and sizing helper for the circuit_bist engine.
package circuit_bist_pkg;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRIVE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Number of 32-bit LFSR words needed to cover one W-bit vector.
    function automatic int calc_k(input int width);
        return (width + 31) / 32;
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit right-shifting Galois LFSR with synchronous seed load and step enable.
module lfsr32_galois
    import circuit_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q,
    output logic [31:0] q_next
);

    logic [31:0] safe_seed;
    logic [31:0] lfsr_d;
    logic [31:0] lfsr_q;

    // An all-zero state would lock up the register, so a zero seed loads 1.
    always_comb begin
        safe_seed = (seed == 32'd0) ? 32'd1 : seed;
        q_next    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
        lfsr_d    = lfsr_q;
        if (load) begin
            lfsr_d = safe_seed;
        end else if (step) begin
            lfsr_d = q_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= safe_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/circuit_bist.sv
// Stimulus/response engine: LFSR-generated vectors driven with an en strobe, Y compacted into a MISR.
module circuit_bist
    import circuit_bist_pkg::*;
#(
    parameter int          W         = 96,
    parameter int          N_VEC     = 100,
    parameter logic [31:0] SEED      = 32'd7,
    parameter int          LAT       = 1,
    parameter logic [W-1:0] MISR_POLY = (W'(1) << 94) | (W'(1) << 49) | (W'(1) << 47) | W'(1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [W-1:0]               X,
    output logic                       en,
    input  logic [W-1:0]               Y,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_VEC+1)-1:0] vec_cnt,
    output logic [W-1:0]               signature
);

    localparam int K  = calc_k(W);
    localparam int XB = K * 32;
    localparam int FW = $clog2(K + 1);
    localparam int VW = $clog2(N_VEC + 1);

    state_e          state_d, state_q;
    logic [FW-1:0]   fill_cnt_d, fill_cnt_q;
    logic [XB-1:0]   xbuf_d, xbuf_q;
    logic [W-1:0]    x_d, x_q;
    logic            en_d, en_q;
    logic [LAT-1:0]  en_pipe_d, en_pipe_q;
    logic [VW-1:0]   vec_cnt_d, vec_cnt_q;
    logic [W-1:0]    sig_d, sig_q;
    logic            lfsr_load;
    logic            lfsr_step;
    logic [31:0]     lfsr_next;
    logic [31:0]     lfsr_unused;

    lfsr32_galois u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .seed   (SEED),
        .step   (lfsr_step),
        .q      (lfsr_unused),
        .q_next (lfsr_next)
    );

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        xbuf_d     = xbuf_q;
        x_d        = x_q;
        en_d       = 1'b0;
        en_pipe_d  = LAT'({en_pipe_q, en_q});
        vec_cnt_d  = vec_cnt_q;
        sig_d      = sig_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;

        if (en_pipe_q[LAT-1]) begin
            sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? MISR_POLY : '0) ^ Y;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    lfsr_load  = 1'b1;
                    sig_d      = '0;
                    vec_cnt_d  = '0;
                    fill_cnt_d = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                lfsr_step = 1'b1;
                xbuf_d    = (xbuf_q << 32) | XB'(lfsr_next);
                if (fill_cnt_q == FW'(K - 1)) begin
                    state_d = ST_DRIVE;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            ST_DRIVE: begin
                x_d        = xbuf_q[W-1:0];
                en_d       = 1'b1;
                fill_cnt_d = '0;
                if (vec_cnt_q != VW'(N_VEC)) begin
                    vec_cnt_d = vec_cnt_q + 1'b1;
                end
                state_d = (vec_cnt_d == VW'(N_VEC)) ? ST_DRAIN : ST_FILL;
            end
            // Leave once the final capture is happening on this edge.
            ST_DRAIN: begin
                if (en_pipe_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            xbuf_q     <= '0;
            x_q        <= '0;
            en_q       <= 1'b0;
            en_pipe_q  <= '0;
            vec_cnt_q  <= '0;
            sig_q      <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            xbuf_q     <= xbuf_d;
            x_q        <= x_d;
            en_q       <= en_d;
            en_pipe_q  <= en_pipe_d;
            vec_cnt_q  <= vec_cnt_d;
            sig_q      <= sig_d;
        end
    end

    assign X         = x_q;
    assign en        = en_q;
    assign busy      = (state_q == ST_FILL) || (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign vec_cnt   = vec_cnt_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_circuit_bist.sv
// Scoreboarded bench for circuit_bist: vector sequence, timing, restart, reset and seed handling.
module tb_circuit_bist;

    localparam logic [95:0] POLY96 = (96'd1 << 94) | (96'd1 << 49) | (96'd1 << 47) | 96'd1;
    localparam logic [95:0] POLY32 = 96'h80200003;

    logic clk = 1'b0;
    logic rst;
    logic zero_y;
    logic start1, start2, start3, start4;

    logic [31:0] x1, y1, sig1;
    logic        en1, busy1, done1;
    logic [0:0]  vc1;
    logic [95:0] x2, y2, sig2, y2_reg;
    logic        en2, busy2, done2;
    logic [1:0]  vc2;
    logic [95:0] x3, y3, sig3;
    logic        en3, busy3, done3;
    logic [6:0]  vc3;
    logic [31:0] x4, y4, sig4;
    logic        en4, busy4, done4;
    logic [2:0]  vc4;

    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;

    logic [95:0] q1[$];
    logic [95:0] q2[$];
    logic [95:0] q3[$];
    logic [95:0] q4[$];
    int          en_cyc2[$];
    logic [95:0] exp_sig [1:4];

    circuit_bist #(.W(32), .N_VEC(1), .SEED(32'd1), .LAT(1), .MISR_POLY(32'h80200003)) u1 (
        .clk(clk), .rst(rst), .start(start1), .X(x1), .en(en1), .Y(y1),
        .busy(busy1), .done(done1), .vec_cnt(vc1), .signature(sig1)
    );
    circuit_bist #(.W(96), .N_VEC(3), .SEED(32'd7), .LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .X(x2), .en(en2), .Y(y2),
        .busy(busy2), .done(done2), .vec_cnt(vc2), .signature(sig2)
    );
    circuit_bist #(.W(96), .N_VEC(100), .SEED(32'd7), .LAT(1)) u3 (
        .clk(clk), .rst(rst), .start(start3), .X(x3), .en(en3), .Y(y3),
        .busy(busy3), .done(done3), .vec_cnt(vc3), .signature(sig3)
    );
    circuit_bist #(.W(32), .N_VEC(4), .SEED(32'd0), .LAT(1), .MISR_POLY(32'h80200003)) u4 (
        .clk(clk), .rst(rst), .start(start4), .X(x4), .en(en4), .Y(y4),
        .busy(busy4), .done(done4), .vec_cnt(vc4), .signature(sig4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        y2_reg <= x2;
    end

    assign y1 = x1;
    assign y2 = zero_y ? 96'd0 : y2_reg;
    assign y3 = x3;
    assign y4 = x4;

    task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsrNext(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic logic [95:0] misrStep(input logic [95:0] s, input logic [95:0] y,
                                             input logic [95:0] poly, input int w);
        logic [95:0] mask;
        logic        top;
        mask = (w == 96) ? {96{1'b1}} : ((96'd1 << w) - 96'd1);
        top  = s[w-1];
        return ((s << 1) & mask) ^ (top ? poly : 96'd0) ^ y;
    endfunction

    // Reference model: fills the unit's queue with expected vectors and records the final signature.
    task automatic buildRun(input int unit, input bit zy);
        int          w, n, k;
        logic [31:0] seed, l;
        logic [95:0] poly, vec, sig, mask;
        case (unit)
            1:       begin w = 32; n = 1;   seed = 32'd1; poly = POLY32; end
            2:       begin w = 96; n = 3;   seed = 32'd7; poly = POLY96; end
            3:       begin w = 96; n = 100; seed = 32'd7; poly = POLY96; end
            default: begin w = 32; n = 4;   seed = 32'd0; poly = POLY32; end
        endcase
        k    = (w + 31) / 32;
        mask = (w == 96) ? {96{1'b1}} : ((96'd1 << w) - 96'd1);
        l    = (seed == 32'd0) ? 32'd1 : seed;
        sig  = 96'd0;
        for (int v = 0; v < n; v++) begin
            vec = 96'd0;
            for (int j = 0; j < k; j++) begin
                l   = lfsrNext(l);
                vec = (vec << 32) | {64'd0, l};
            end
            vec = vec & mask;
            case (unit)
                1:       q1.push_back(vec);
                2:       q2.push_back(vec);
                3:       q3.push_back(vec);
                default: q4.push_back(vec);
            endcase
            sig = misrStep(sig, zy ? 96'd0 : vec, poly, w);
        end
        exp_sig[unit] = sig;
    endtask

    // Called at a negedge; returns at the next negedge with t = index of the edge that sampled start.
    task automatic applyStimulus(input int unit, input bit zy, output int t);
        buildRun(unit, zy);
        case (unit)
            1:       start1 = 1'b1;
            2:       start2 = 1'b1;
            3:       start3 = 1'b1;
            default: start4 = 1'b1;
        endcase
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
        t = cyc;
    endtask

    function automatic logic getDone(input int unit);
        case (unit)
            1:       return done1;
            2:       return done2;
            3:       return done3;
            default: return done4;
        endcase
    endfunction

    function automatic logic getBusy(input int unit);
        case (unit)
            1:       return busy1;
            2:       return busy2;
            3:       return busy3;
            default: return busy4;
        endcase
    endfunction

    task automatic waitDone(input int unit, input int budget, output int dcyc, output int busy_low);
        dcyc     = -1;
        busy_low = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (getDone(unit)) begin
                dcyc = cyc;
                break;
            end
            if (!getBusy(unit)) busy_low++;
        end
        if (dcyc < 0) checkOutput($sformatf("u%0d_done_timeout", unit), 96'd0, 96'd1);
    endtask

    task automatic scoreX(input int unit, input logic [95:0] xv);
        logic [95:0] e;
        int          sz;
        case (unit)
            1:       sz = q1.size();
            2:       sz = q2.size();
            3:       sz = q3.size();
            default: sz = q4.size();
        endcase
        if (sz == 0) begin
            checkOutput($sformatf("u%0d_extra_en", unit), 96'd1, 96'd0);
        end else begin
            case (unit)
                1:       e = q1.pop_front();
                2:       e = q2.pop_front();
                3:       e = q3.pop_front();
                default: e = q4.pop_front();
            endcase
            checkOutput($sformatf("u%0d_X", unit), xv, e);
        end
    endtask

    always @(negedge clk) begin
        if (en1) scoreX(1, {64'd0, x1});
        if (en2) begin
            scoreX(2, x2);
            en_cyc2.push_back(int'(cyc));
        end
        if (en3) scoreX(3, x3);
        if (en4) scoreX(4, {64'd0, x4});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          t, d, bl;
        bit          found;
        logic [95:0] ref_sig2;

        rst    = 1'b1;
        zero_y = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_X",     x2,    96'd0);
        checkOutput("rst_en",    en2,   96'd0);
        checkOutput("rst_busy",  busy2, 96'd0);
        checkOutput("rst_done",  done2, 96'd0);
        checkOutput("rst_vcnt",  vc2,   96'd0);
        checkOutput("rst_sig",   sig2,  96'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single vector loopback");
        applyStimulus(1, 1'b0, t);
        checkOutput("u1_busy_t0", busy1, 96'd1);
        checkOutput("u1_en_t0",   en1,   96'd0);
        @(negedge clk);
        checkOutput("u1_en_t1",   en1,   96'd0);
        @(negedge clk);
        checkOutput("u1_en_t2",   en1,   96'd1);
        checkOutput("u1_X_t2",    x1,    96'h80200003);
        @(negedge clk);
        checkOutput("u1_en_t3",   en1,   96'd0);
        checkOutput("u1_done_t3", done1, 96'd0);
        @(negedge clk);
        checkOutput("u1_done_t4", done1, 96'd1);
        checkOutput("u1_sig",     sig1,  96'h80200003);
        checkOutput("u1_vcnt",    vc1,   96'd1);

        $display("[TB] count and spacing");
        en_cyc2.delete();
        applyStimulus(2, 1'b0, t);
        waitDone(2, 100, d, bl);
        checkOutput("u2_en_count", en_cyc2.size(), 96'd3);
        if (en_cyc2.size() == 3) begin
            checkOutput("u2_first_en", en_cyc2[0] - t, 96'd4);
            checkOutput("u2_gap1",     en_cyc2[1] - en_cyc2[0], 96'd4);
            checkOutput("u2_gap2",     en_cyc2[2] - en_cyc2[1], 96'd4);
            checkOutput("u2_done_lag", d - en_cyc2[2], 96'd3);
        end
        checkOutput("u2_busy_gaps", bl,   96'd0);
        checkOutput("u2_vcnt",      vc2,  96'd3);
        checkOutput("u2_sig",       sig2, exp_sig[2]);
        ref_sig2 = exp_sig[2];

        $display("[TB] rerun from done with start while busy");
        en_cyc2.delete();
        applyStimulus(2, 1'b0, t);
        checkOutput("u2_rerun_done_drop", done2, 96'd0);
        checkOutput("u2_rerun_sig_clear", sig2,  96'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en2) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("u2_rerun_first_en", found, 96'd1);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checkOutput("u2_ignore_busy", busy2, 96'd1);
        checkOutput("u2_ignore_vcnt", vc2,   96'd1);
        waitDone(2, 100, d, bl);
        checkOutput("u2_rerun_en_count", en_cyc2.size(), 96'd3);
        checkOutput("u2_rerun_vcnt",     vc2,  96'd3);
        checkOutput("u2_rerun_sig",      sig2, ref_sig2);

        $display("[TB] Y forced to zero");
        zero_y = 1'b1;
        applyStimulus(2, 1'b1, t);
        waitDone(2, 100, d, bl);
        checkOutput("u2_zero_y_sig", sig2, exp_sig[2]);
        zero_y = 1'b0;

        $display("[TB] zero seed");
        applyStimulus(4, 1'b0, t);
        waitDone(4, 100, d, bl);
        checkOutput("u4_sig",  sig4, exp_sig[4]);
        checkOutput("u4_vcnt", vc4,  96'd4);

        $display("[TB] reset mid-run");
        applyStimulus(3, 1'b0, t);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (en3 && vc3 == 7'd49) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("u3_reach_vec49", found, 96'd1);
        repeat (3) @(negedge clk);
        checkOutput("u3_vcnt_pre_rst", vc3, 96'd49);
        rst    = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start3 = 1'b0;
        checkOutput("u3_rst_X",    x3,    96'd0);
        checkOutput("u3_rst_en",   en3,   96'd0);
        checkOutput("u3_rst_busy", busy3, 96'd0);
        checkOutput("u3_rst_done", done3, 96'd0);
        checkOutput("u3_rst_vcnt", vc3,   96'd0);
        checkOutput("u3_rst_sig",  sig3,  96'd0);
        q3.delete();
        @(negedge clk);
        applyStimulus(3, 1'b0, t);
        waitDone(3, 600, d, bl);
        checkOutput("u3_sig",     sig3, exp_sig[3]);
        checkOutput("u3_vcnt",    vc3,  96'd100);
        checkOutput("u3_q_empty", q3.size(), 96'd0);
        checkOutput("u1_q_empty", q1.size(), 96'd0);
        checkOutput("u2_q_empty", q2.size(), 96'd0);
        checkOutput("u4_q_empty", q4.size(), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
